memory_bus_arbiter: RTL and testbench

//  Shares the single memory bus between two requesters: the CPU (fetch/data in FETCH/EXECUTE phases) and the debug port.
//  The debug port is granted only while the phase sequencer reports STOPPED.

---
 rtl/memory_bus_arbiter_pkg.sv | 22 ++
 rtl/arb_wait_counter.sv | 40 ++++
 rtl/memory_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state codes, grant encodings
// and a width helper for the optional wait-state counter.
package memory_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_CPU_ACC  = 3'd1,
        ARB_CPU_DONE = 3'd2,
        ARB_DBG_ACC  = 3'd3,
        ARB_DBG_ACK  = 3'd4
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_CPU  = 2'b01;
    localparam logic [1:0] GRANT_DBG  = 2'b10;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Wait-state down-counter: loads MAX, decrements on dec, flags zero.
// Latency: count visible one cycle after load/dec; no backpressure.
// Backpressure: none, purely driven by the arbiter FSM.
module arb_wait_counter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int MAX = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int W = cnt_width(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(MAX);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/memory_bus_arbiter.sv
// Memory bus arbiter between CPU and debug port; debug is served only while STOPPED.
// Latency: strobe the cycle after REQ is sampled, RDY/ACK after the last access cycle.
// Backpressure: a losing or late requester simply waits with REQ held; BUS_ARB_WAIT_STATES_EN adds wait cycles.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RESETX,
    input  logic              STOPPED,
    input  logic              CPU_REQ,
    input  logic              CPU_WR,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_DOUT,
    output logic [DATA_W-1:0] CPU_DIN,
    output logic              CPU_RDY,
    input  logic              DBG_REQ,
    input  logic              DBG_WR,
    input  logic [ADDR_W-1:0] DBG_ADDR,
    input  logic [DATA_W-1:0] DBG_DOUT,
    output logic [DATA_W-1:0] DBG_DIN,
    output logic              DBG_ACK,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DOUT,
    input  logic [DATA_W-1:0] MEM_DIN,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [1:0]        GRANT,
    output logic              BUSY
);

    arb_state_t        state_q,    state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
    logic [DATA_W-1:0] cpu_din_q,  cpu_din_d;
    logic [DATA_W-1:0] dbg_din_q,  dbg_din_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              mem_wr_q,   mem_wr_d;
    logic              cpu_rdy_q,  cpu_rdy_d;
    logic              dbg_ack_q,  dbg_ack_d;
    logic [1:0]        grant_q,    grant_d;
    logic              busy_q,     busy_d;

    logic acc_load;
    logic acc_dec;
    logic acc_last;

`ifdef BUS_ARB_WAIT_STATES_EN
    arb_wait_counter #(
        .MAX (WAIT_CYCLES)
    ) u_wait_cnt (
        .clk   (CLK),
        .rst_n (RESETX),
        .load  (acc_load),
        .dec   (acc_dec),
        .zero  (acc_last)
    );
`else
    // Single-cycle access: every ACC cycle is the last one.
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES != 0) ^ acc_load ^ acc_dec;
    assign acc_last        = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        cpu_din_d  = cpu_din_q;
        dbg_din_d  = dbg_din_q;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        cpu_rdy_d  = 1'b0;
        dbg_ack_d  = 1'b0;
        grant_d    = GRANT_NONE;
        acc_load   = 1'b0;
        acc_dec    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (CPU_REQ) begin
                    state_d    = ARB_CPU_ACC;
                    mem_addr_d = CPU_ADDR;
                    mem_dout_d = CPU_DOUT;
                    mem_rd_d   = ~CPU_WR;
                    mem_wr_d   = CPU_WR;
                    grant_d    = GRANT_CPU;
                    acc_load   = 1'b1;
                end else if (DBG_REQ && STOPPED) begin
                    state_d    = ARB_DBG_ACC;
                    mem_addr_d = DBG_ADDR;
                    mem_dout_d = DBG_DOUT;
                    mem_rd_d   = ~DBG_WR;
                    mem_wr_d   = DBG_WR;
                    grant_d    = GRANT_DBG;
                    acc_load   = 1'b1;
                end
            end
            ARB_CPU_ACC: begin
                grant_d = GRANT_CPU;
                if (acc_last) begin
                    state_d   = ARB_CPU_DONE;
                    cpu_rdy_d = 1'b1;
                    if (mem_rd_q) begin
                        cpu_din_d = MEM_DIN;
                    end
                end else begin
                    mem_rd_d = mem_rd_q;
                    mem_wr_d = mem_wr_q;
                    acc_dec  = 1'b1;
                end
            end
            // REQ is deliberately ignored here so the CPU has a cycle to drop it.
            ARB_CPU_DONE: begin
                state_d = ARB_IDLE;
            end
            ARB_DBG_ACC: begin
                grant_d = GRANT_DBG;
                if (acc_last) begin
                    state_d   = ARB_DBG_ACK;
                    dbg_ack_d = 1'b1;
                    if (mem_rd_q) begin
                        dbg_din_d = MEM_DIN;
                    end
                end else begin
                    mem_rd_d = mem_rd_q;
                    mem_wr_d = mem_wr_q;
                    acc_dec  = 1'b1;
                end
            end
            ARB_DBG_ACK: begin
                if (!DBG_REQ) begin
                    state_d = ARB_IDLE;
                end else begin
                    dbg_ack_d = 1'b1;
                    grant_d   = GRANT_DBG;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge CLK or negedge RESETX) begin
        if (!RESETX) begin
            state_q    <= ARB_IDLE;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
            cpu_din_q  <= '0;
            dbg_din_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            cpu_rdy_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            grant_q    <= GRANT_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            cpu_din_q  <= cpu_din_d;
            dbg_din_q  <= dbg_din_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            cpu_rdy_q  <= cpu_rdy_d;
            dbg_ack_q  <= dbg_ack_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign MEM_ADDR = mem_addr_q;
    assign MEM_DOUT = mem_dout_q;
    assign CPU_DIN  = cpu_din_q;
    assign DBG_DIN  = dbg_din_q;
    assign MEM_RD   = mem_rd_q;
    assign MEM_WR   = mem_wr_q;
    assign CPU_RDY  = cpu_rdy_q;
    assign DBG_ACK  = dbg_ack_q;
    assign GRANT    = grant_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter; outputs sampled 1ns after each rising edge.
module tb_memory_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WC = 3;
`ifdef BUS_ARB_WAIT_STATES_EN
    localparam int EXP_ACC = WC + 1;
`else
    localparam int EXP_ACC = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          stopped = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_dout = '0;
    logic [DW-1:0] cpu_din;
    logic          cpu_rdy;
    logic          dbg_req = 1'b0;
    logic          dbg_wr = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_dout = '0;
    logic [DW-1:0] dbg_din;
    logic          dbg_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem_din = '0;
    logic          mem_rd;
    logic          mem_wr;
    logic [1:0]    grant;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    memory_bus_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (WC)
    ) dut (
        .CLK      (clk),
        .RESETX   (rstn),
        .STOPPED  (stopped),
        .CPU_REQ  (cpu_req),
        .CPU_WR   (cpu_wr),
        .CPU_ADDR (cpu_addr),
        .CPU_DOUT (cpu_dout),
        .CPU_DIN  (cpu_din),
        .CPU_RDY  (cpu_rdy),
        .DBG_REQ  (dbg_req),
        .DBG_WR   (dbg_wr),
        .DBG_ADDR (dbg_addr),
        .DBG_DOUT (dbg_dout),
        .DBG_DIN  (dbg_din),
        .DBG_ACK  (dbg_ack),
        .MEM_ADDR (mem_addr),
        .MEM_DOUT (mem_dout),
        .MEM_DIN  (mem_din),
        .MEM_RD   (mem_rd),
        .MEM_WR   (mem_wr),
        .GRANT    (grant),
        .BUSY     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {mem_rd, mem_wr, cpu_rdy, dbg_ack, grant, busy}
    function automatic logic [6:0] ctl();
        return {mem_rd, mem_wr, cpu_rdy, dbg_ack, grant, busy};
    endfunction

    initial begin
        int rd_cycles;
        int rdy_cycle;

        #3;
        chk("reset_ctl", 32'(ctl()), 32'h0);
        chk("reset_data", {cpu_din, dbg_din}, 32'h0);
        chk("reset_bus", {mem_addr, mem_dout}, 32'h0);
        step();
        rstn = 1'b1;
        step();

        // 1: CPU read
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h1234; mem_din = 16'hBEEF;
        step();
        chk("t1_acc_ctl", 32'(ctl()), 32'b1000011);
        chk("t1_acc_addr", 32'(mem_addr), 32'h1234);
        step();
        chk("t1_done_ctl", 32'(ctl()), 32'b0010011);
        chk("t1_din", 32'(cpu_din), 32'hBEEF);
        cpu_req = 1'b0;
        step();
        chk("t1_idle_ctl", 32'(ctl()), 32'b0000000);
        chk("t1_din_hold", 32'(cpu_din), 32'hBEEF);

        // 2: debug write blocked until STOPPED
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'h0010; dbg_dout = 16'h5A5A;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_blocked", 32'(ctl()), 32'b0000000);
        end
        stopped = 1'b1;
        step();
        chk("t2_acc_ctl", 32'(ctl()), 32'b0100101);
        chk("t2_acc_bus", {mem_addr, mem_dout}, 32'h00105A5A);
        step();
        chk("t2_ack_ctl", 32'(ctl()), 32'b0001101);
        step();
        chk("t2_ack_hold", 32'(ctl()), 32'b0001101);
        dbg_req = 1'b0;
        step();
        chk("t2_idle_ctl", 32'(ctl()), 32'b0000000);
        chk("t2_din_unch", 32'(dbg_din), 32'h0);
        chk("t2_bus_hold", {mem_addr, mem_dout}, 32'h00105A5A);

        // 3: simultaneous requests, CPU first
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h2000; mem_din = 16'h1111;
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 16'h3000;
        step();
        chk("t3_cpu_acc", 32'(ctl()), 32'b1000011);
        chk("t3_cpu_addr", 32'(mem_addr), 32'h2000);
        step();
        chk("t3_cpu_done", 32'(ctl()), 32'b0010011);
        chk("t3_cpu_din", 32'(cpu_din), 32'h1111);
        cpu_req = 1'b0;
        step();
        chk("t3_idle_gap", 32'(ctl()), 32'b0000000);
        mem_din = 16'h2222;
        step();
        chk("t3_dbg_acc", 32'(ctl()), 32'b1000101);
        chk("t3_dbg_addr", 32'(mem_addr), 32'h3000);
        step();
        chk("t3_dbg_ack", 32'(ctl()), 32'b0001101);
        chk("t3_dbg_din", 32'(dbg_din), 32'h2222);

        // 4: CPU request while debug holds ACK
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h4000; mem_din = 16'h4444;
        step();
        chk("t4_wait1", 32'(ctl()), 32'b0001101);
        step();
        chk("t4_wait2", 32'(ctl()), 32'b0001101);
        dbg_req = 1'b0;
        step();
        chk("t4_idle", 32'(ctl()), 32'b0000000);
        step();
        chk("t4_cpu_acc", 32'(ctl()), 32'b1000011);
        chk("t4_cpu_addr", 32'(mem_addr), 32'h4000);
        step();
        chk("t4_cpu_done", 32'(ctl()), 32'b0010011);
        chk("t4_cpu_din", 32'(cpu_din), 32'h4444);
        cpu_req = 1'b0;
        step();

        // 5: async reset mid-access
        stopped = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h5555; cpu_dout = 16'hAAAA;
        step();
        chk("t5_acc_ctl", 32'(ctl()), 32'b0100011);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_ctl", 32'(ctl()), 32'h0);
        chk("t5_rst_data", {cpu_din, dbg_din}, 32'h0);
        chk("t5_rst_bus", {mem_addr, mem_dout}, 32'h0);
        cpu_req = 1'b0;
        step();
        chk("t5_in_rst", 32'(ctl()), 32'h0);
        #3;
        rstn = 1'b1;
        step();
        chk("t5_no_rdy", 32'(ctl()), 32'h0);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0042; mem_din = 16'h00C3;
        step();
        chk("t5_new_acc", 32'(ctl()), 32'b1000011);
        step();
        chk("t5_new_done", 32'(ctl()), 32'b0010011);
        chk("t5_new_din", 32'(cpu_din), 32'h00C3);
        cpu_req = 1'b0;
        step();

        // 6: access length measured cycle by cycle
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0600; mem_din = 16'h0606;
        rd_cycles = 0;
        rdy_cycle = 0;
        for (int c = 1; c <= 20 && rdy_cycle == 0; c++) begin
            step();
            if (mem_rd) rd_cycles++;
            if (cpu_rdy) rdy_cycle = c;
        end
        cpu_req = 1'b0;
        chk("t6_rd_cycles", 32'(rd_cycles), 32'(EXP_ACC));
        chk("t6_rdy_cycle", 32'(rdy_cycle), 32'(EXP_ACC + 1));
        chk("t6_din", 32'(cpu_din), 32'h0606);
        step();
        step();
        chk("t6_idle", 32'(ctl()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
